// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand-forward select and load-use stall control for the 5-stage core.
// Optional macro FORWARDING_EN: when undefined, selects stay 00 and stall covers every EX/MEM RAW.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  ex_valid
);

    // EX stage state
    logic                  r_ex_valid, r_ex_uses1, r_ex_uses2, r_ex_rw, r_ex_mr;
    logic [REG_ADDR_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
    // MEM stage state
    logic                  r_mem_valid, r_mem_rw, r_mem_mr;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    // WB stage state
    logic                  r_wb_valid, r_wb_rw;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    logic w_stall_raw;
    logic w_bubble;

    // A stage really writes only if it is live, enabled and not targeting x0.
    function automatic logic rd_writes(input logic v, input logic w,
                                       input logic [REG_ADDR_W-1:0] rd);
        return v & w & (rd != '0) & (32'(rd) < 32'(NUM_REGS));
    endfunction

    assign stall    = w_stall_raw & ~flush;
    assign w_bubble = w_stall_raw | flush;
    assign ex_valid = r_ex_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_uses1  <= 1'b0;
            r_ex_uses2  <= 1'b0;
            r_ex_rw     <= 1'b0;
            r_ex_mr     <= 1'b0;
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_rd     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_mr    <= 1'b0;
            r_mem_rd    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rw     <= 1'b0;
            r_wb_rd     <= '0;
        end else begin
            r_wb_valid  <= r_mem_valid;
            r_wb_rw     <= r_mem_rw;
            r_wb_rd     <= r_mem_rd;
            r_mem_valid <= r_ex_valid;
            r_mem_rw    <= r_ex_rw;
            r_mem_mr    <= r_ex_mr;
            r_mem_rd    <= r_ex_rd;
            r_ex_rs1    <= id_rs1;
            r_ex_rs2    <= id_rs2;
            r_ex_uses1  <= id_uses_rs1;
            r_ex_uses2  <= id_uses_rs2;
            r_ex_rd     <= id_rd;
            r_ex_valid  <= id_valid & ~w_bubble;
            r_ex_rw     <= id_reg_write & ~w_bubble;
            r_ex_mr     <= id_mem_read & ~w_bubble;
        end
    end

`ifdef FORWARDING_EN
    logic w_mem_wr, w_wb_wr;
    logic w_ld_hit1, w_ld_hit2;

    // Loads in MEM have no ALU result yet, so they are excluded from the MEM path.
    assign w_mem_wr = rd_writes(r_mem_valid, r_mem_rw, r_mem_rd) & ~r_mem_mr;
    assign w_wb_wr  = rd_writes(r_wb_valid, r_wb_rw, r_wb_rd);

    always_comb begin
        fwd_a_sel = 2'b00;
        if (r_ex_valid && r_ex_uses1 && w_mem_wr && (r_mem_rd == r_ex_rs1))
            fwd_a_sel = 2'b10;
        else if (r_ex_valid && r_ex_uses1 && w_wb_wr && (r_wb_rd == r_ex_rs1))
            fwd_a_sel = 2'b01;
    end

    always_comb begin
        fwd_b_sel = 2'b00;
        if (r_ex_valid && r_ex_uses2 && w_mem_wr && (r_mem_rd == r_ex_rs2))
            fwd_b_sel = 2'b10;
        else if (r_ex_valid && r_ex_uses2 && w_wb_wr && (r_wb_rd == r_ex_rs2))
            fwd_b_sel = 2'b01;
    end

    assign w_ld_hit1   = id_uses_rs1 & (id_rs1 == r_ex_rd);
    assign w_ld_hit2   = id_uses_rs2 & (id_rs2 == r_ex_rd);
    assign w_stall_raw = id_valid & r_ex_valid & r_ex_mr & (r_ex_rd != '0)
                       & (w_ld_hit1 | w_ld_hit2);
`else
    logic w_ex_wr, w_mem_wr;
    logic w_hit1, w_hit2;
    logic w_unused_nofwd;

    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;

    // Without bypass paths, any in-flight EX/MEM writer of a source must drain to WB first.
    assign w_ex_wr  = rd_writes(r_ex_valid, r_ex_rw, r_ex_rd);
    assign w_mem_wr = rd_writes(r_mem_valid, r_mem_rw, r_mem_rd);
    assign w_hit1   = id_uses_rs1 & (id_rs1 != '0)
                    & ((w_ex_wr & (id_rs1 == r_ex_rd)) | (w_mem_wr & (id_rs1 == r_mem_rd)));
    assign w_hit2   = id_uses_rs2 & (id_rs2 != '0)
                    & ((w_ex_wr & (id_rs2 == r_ex_rd)) | (w_mem_wr & (id_rs2 == r_mem_rd)));
    assign w_stall_raw = id_valid & (w_hit1 | w_hit2);

    assign w_unused_nofwd = ^{r_ex_rs1, r_ex_rs2, r_ex_uses1, r_ex_uses2, r_ex_mr,
                              r_mem_mr, r_wb_valid, r_wb_rw, r_wb_rd};
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; expectations follow the FORWARDING_EN build setting.
module tb_fwd_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, ex_valid;
    int         n_tests = 0;
    int         n_fail  = 0;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] a, input logic [1:0] b,
                           input logic s, input logic ev);
        chk({tag, ".fwd_a"}, fwd_a_sel, a);
        chk({tag, ".fwd_b"}, fwd_b_sel, b);
        chk({tag, ".stall"}, {1'b0, stall}, {1'b0, s});
        chk({tag, ".ex_valid"}, {1'b0, ex_valid}, {1'b0, ev});
    endtask

    // Apply an ID instruction; outputs are checked 1 time unit later.
    task automatic id(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic rw, input logic mr);
        id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
        #1;
    endtask

    task automatic nop();
        id_valid = 1'b0; id_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        id(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk_all("rst1", 2'b00, 2'b00, 1'b0, 1'b0);
        id(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("rst2", 2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        drain();

`ifdef FORWARDING_EN
        // add x5; sub x6 <- x5, x7
        id(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        id(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("adj.stall", {1'b0, stall}, 2'b00);
        tick(); nop();
        chk_all("adj", 2'b10, 2'b00, 1'b0, 1'b1);
        drain();

        // add x5; or x11; sub x6 <- x5, x7
        id(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        id(5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        id(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0); tick(); nop();
        chk_all("gap", 2'b01, 2'b00, 1'b0, 1'b1);
        drain();

        // add x5; add x5; sub x6 <- x7, x5 (MEM and WB both hit, on operand B)
        id(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        id(5'd5, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        id(5'd6, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); tick(); nop();
        chk_all("dbl", 2'b00, 2'b10, 1'b0, 1'b1);
        drain();

        // lw x8; add x9 <- x1, x8
        id(5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        id(5'd9, 5'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("ldu.s1", 2'b00, 2'b00, 1'b1, 1'b1);
        tick();
        chk_all("ldu.bub", 2'b00, 2'b00, 1'b0, 1'b0);
        tick(); nop();
        chk_all("ldu.use", 2'b00, 2'b01, 1'b0, 1'b1);
        drain();

        // addi x0; add x3 <- x0, x0; lw x0; use x0
        id(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        id(5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        id(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_all("x0.alu", 2'b00, 2'b00, 1'b0, 1'b1);
        tick();
        id(5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("x0.ld.stall", {1'b0, stall}, 2'b00);
        drain();

        // lw x8; add x9 <- x1, x8 squashed by flush; then use x9
        id(5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        id(5'd9, 5'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        flush = 1'b1; #1;
        chk("fl.stall", {1'b0, stall}, 2'b00);
        tick();
        flush = 1'b0;
        id(5'd10, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("fl.exv", {1'b0, ex_valid}, 2'b00);
        tick(); nop();
        chk_all("fl.nofwd", 2'b00, 2'b00, 1'b0, 1'b1);
        drain();

        // reset while a load-use stall is pending
        id(5'd12, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        id(5'd13, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rs.pre", {1'b0, stall}, 2'b01);
        rst_n = 1'b0; tick();
        chk_all("rs.post", 2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        drain();
`else
        // add x5; sub x6 <- x5, x7 stalls two cycles
        id(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("adj.pre", {1'b0, stall}, 2'b00);
        tick();
        id(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("adj.s1", 2'b00, 2'b00, 1'b1, 1'b1);
        tick();
        chk_all("adj.s2", 2'b00, 2'b00, 1'b1, 1'b0);
        tick();
        chk_all("adj.go", 2'b00, 2'b00, 1'b0, 1'b0);
        tick(); nop();
        chk_all("adj.ex", 2'b00, 2'b00, 1'b0, 1'b1);
        drain();

        // add x10; or x11; use x10 stalls one cycle
        id(5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        id(5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("gap.indep", {1'b0, stall}, 2'b00);
        tick();
        id(5'd6, 5'd3, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("gap.s1", {1'b0, stall}, 2'b01);
        tick();
        chk_all("gap.go", 2'b00, 2'b00, 1'b0, 1'b0);
        drain();

        // load followed by use behaves the same as an ALU producer
        id(5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        id(5'd9, 5'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("ldu.s1", {1'b0, stall}, 2'b01);
        tick();
        chk("ldu.s2", {1'b0, stall}, 2'b01);
        tick();
        chk("ldu.go", {1'b0, stall}, 2'b00);
        drain();

        // x0 writers never stall
        id(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        id(5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("x0.stall", {1'b0, stall}, 2'b00);
        drain();

        // flush overrides a pending hazard and squashes the ID instruction
        id(5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        id(5'd9, 5'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        flush = 1'b1; #1;
        chk("fl.stall", {1'b0, stall}, 2'b00);
        tick();
        flush = 1'b0; nop();
        chk("fl.exv", {1'b0, ex_valid}, 2'b00);
        drain();

        // reset while stalled clears all tracked writers
        id(5'd12, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        id(5'd13, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rs.pre", {1'b0, stall}, 2'b01);
        rst_n = 1'b0; tick();
        chk_all("rs.post", 2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
